// File: rtl/gencon.sv
// Keypad calculator controller: builds two signed decimal operands, latches an
// operator and produces a wrapped 16-bit result (multiply is a serial shift-add).
package gencon_defs;
  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ACC_A    = 3'd1,
    OP_LATCH = 3'd2,
    ENTER_B  = 3'd3,
    ACC_B    = 3'd4,
    COMPUTE  = 3'd5,
    DONE     = 3'd6
  } state_t;
endpackage

module gencon
  import gencon_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             complete,
  output logic [WIDTH-1:0] display_output,
  output state_t           tb_current_state
);

  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int         CW     = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic             complete_q, complete_d;
  logic             hold_q, hold_d;
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d, mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;

  logic             digit_ok, op_arith, finish;
  logic [WIDTH-1:0] digit_ext, mag_a_next, mag_b_next, b_val, res, acc_step;

  always_comb begin
    state_d      = state_q;
    mag_a_d      = mag_a_q;
    mag_b_d      = mag_b_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    display_d    = display_q;
    complete_d   = 1'b0;
    hold_d       = hold_q;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    finish       = 1'b0;
    res          = '0;

    digit_ok   = read_input && (keypad_input <= 4'd9);
    op_arith   = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                 (operator_input == OP_MUL);
    digit_ext  = WIDTH'(keypad_input);
    mag_a_next = mag_a_q * WIDTH'(10) + digit_ext;
    mag_b_next = mag_b_q * WIDTH'(10) + digit_ext;
    b_val      = sign_b_q ? -mag_b_q : mag_b_q;
    acc_step   = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);

    unique case (state_q)
      ENTER_A: begin
        if (op_arith) begin
          op_d    = operator_input;
          a_d     = sign_a_q ? -mag_a_q : mag_a_q;
          state_d = OP_LATCH;
        end else if (operator_input == OP_NEG) begin
          sign_a_d = ~sign_a_q;
          // A finished result stays visible until a new digit arrives
          if (!hold_q) display_d = sign_a_q ? mag_a_q : -mag_a_q;
        end else if (digit_ok) begin
          mag_a_d   = mag_a_next;
          display_d = sign_a_q ? -mag_a_next : mag_a_next;
          hold_d    = 1'b0;
          state_d   = ACC_A;
        end
      end
      ACC_A: state_d = ENTER_A;
      OP_LATCH: begin
        mag_b_d  = '0;
        sign_b_d = 1'b0;
        state_d  = ENTER_B;
      end
      ENTER_B: begin
        if (equal_input) begin
          b_d          = b_val;
          mul_acc_d    = '0;
          mul_mcand_d  = a_q;
          mul_mplier_d = b_val;
          mul_cnt_d    = '0;
          state_d      = COMPUTE;
        end else if (operator_input == OP_NEG) begin
          sign_b_d  = ~sign_b_q;
          display_d = sign_b_q ? mag_b_q : -mag_b_q;
        end else if (digit_ok) begin
          mag_b_d   = mag_b_next;
          display_d = sign_b_q ? -mag_b_next : mag_b_next;
          hold_d    = 1'b0;
          state_d   = ACC_B;
        end
      end
      ACC_B: state_d = ENTER_B;
      COMPUTE: begin
        if (op_q == OP_ADD) begin
          res    = a_q + b_q;
          finish = 1'b1;
        end else if (op_q == OP_SUB) begin
          res    = a_q - b_q;
          finish = 1'b1;
        end else begin
          // Low bits of a two's-complement product match the unsigned product
          mul_acc_d    = acc_step;
          mul_mcand_d  = mul_mcand_q << 1;
          mul_mplier_d = mul_mplier_q >> 1;
          mul_cnt_d    = mul_cnt_q + 1'b1;
          if (mul_cnt_q == CW'(WIDTH - 1)) begin
            res    = acc_step;
            finish = 1'b1;
          end
        end
        if (finish) begin
          display_d  = res;
          complete_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        mag_a_d  = '0;
        mag_b_d  = '0;
        sign_a_d = 1'b0;
        sign_b_d = 1'b0;
        hold_d   = 1'b1;
        state_d  = ENTER_A;
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q      <= ENTER_A;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      display_q    <= '0;
      complete_q   <= 1'b0;
      hold_q       <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mag_a_q      <= mag_a_d;
      mag_b_q      <= mag_b_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      display_q    <= display_d;
      complete_q   <= complete_d;
      hold_q       <= hold_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end

  assign complete         = complete_q;
  assign display_output   = display_q;
  assign tb_current_state = state_q;

endmodule

// File: tb/tb_gencon.sv
// Scoreboard bench for gencon: expected results are queued when "equal" is
// pressed and compared when the complete pulse appears.
module tb_gencon;
  import gencon_defs::*;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  state_t      cur_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  gencon #(.WIDTH(16)) dut (
    .clk              (clk),
    .nRST             (nRST),
    .keypad_input     (keypad_input),
    .read_input       (read_input),
    .operator_input   (operator_input),
    .equal_input      (equal_input),
    .complete         (complete),
    .display_output   (display_output),
    .tb_current_state (cur_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic press_digit(input logic [3:0] d);
    keypad_input = d;
    read_input   = 1'b1;
    @(negedge clk);
    read_input   = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_op(input logic [2:0] o);
    operator_input = o;
    @(negedge clk);
    operator_input = 3'b000;
    @(negedge clk);
  endtask

  task automatic enter_operand(input bit neg, input int value);
    int digs[$];
    int v;
    v = value;
    do begin
      digs.push_front(v % 10);
      v = v / 10;
    end while (v > 0);
    if (neg) press_op(3'b001);
    foreach (digs[i]) press_digit(4'(digs[i]));
  endtask

  function automatic logic [15:0] model(input bit neg_a, input int a, input logic [2:0] op,
                                        input bit neg_b, input int b);
    logic [15:0] sa, sb, p;
    logic [31:0] full;
    sa = neg_a ? -16'(a) : 16'(a);
    sb = neg_b ? -16'(b) : 16'(b);
    full = 32'(sa) * 32'(sb);
    p = full[15:0];
    case (op)
      3'b010:  return sa + sb;
      3'b011:  return sa - sb;
      default: return p;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input bit neg_a, input int a,
                               input logic [2:0] op, input bit neg_b, input int b,
                               input bit hold_eq, input bit add_in_b);
    logic [15:0] sa, exp;
    int n;
    sa = neg_a ? -16'(a) : 16'(a);
    enter_operand(neg_a, a);
    checkOutput({tag, "_entry_a"}, display_output, sa);
    press_op(op);
    checkOutput({tag, "_state_b"}, 16'(cur_state), 16'(ENTER_B));
    enter_operand(neg_b, b);
    if (add_in_b) begin
      press_op(3'b010);
      checkOutput({tag, "_add_ignored"}, 16'(cur_state), 16'(ENTER_B));
    end
    exp_q.push_back(model(neg_a, a, op, neg_b, b));
    equal_input = 1'b1;
    @(negedge clk);
    if (!hold_eq) equal_input = 1'b0;
    n = 0;
    while (!complete && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    if (!complete) begin
      checkOutput({tag, "_complete_timeout"}, 16'(complete), 16'd1);
    end else begin
      checkOutput({tag, "_result"}, display_output, exp);
      checkOutput({tag, "_done_state"}, 16'(cur_state), 16'(DONE));
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, 16'(complete), 16'd0);
      checkOutput({tag, "_back_to_a"}, 16'(cur_state), 16'(ENTER_A));
      checkOutput({tag, "_result_held"}, display_output, exp);
      if (hold_eq) begin
        repeat (4) begin
          @(negedge clk);
          checkOutput({tag, "_eq_hold_state"}, 16'(cur_state), 16'(ENTER_A));
          checkOutput({tag, "_eq_hold_complete"}, 16'(complete), 16'd0);
        end
        equal_input = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b0;
  endtask

  initial begin
    int late;
    nRST = 1'b1;
    keypad_input = 4'd0;
    read_input = 1'b0;
    operator_input = 3'b000;
    equal_input = 1'b0;
    do_reset();
    checkOutput("reset_state", 16'(cur_state), 16'(ENTER_A));
    checkOutput("reset_complete", 16'(complete), 16'd0);
    checkOutput("reset_display", display_output, 16'h0000);

    applyStimulus("add_2_3",      0, 2,     3'b010, 0, 3,     0, 0);
    applyStimulus("add_n25_n15",  1, 25,    3'b010, 1, 15,    0, 0);
    applyStimulus("add_n10_10",   1, 10,    3'b010, 0, 10,    0, 0);
    applyStimulus("add_min_max",  1, 32768, 3'b010, 0, 32767, 0, 0);
    applyStimulus("add_1000",     0, 1000,  3'b010, 0, 2345,  0, 0);
    applyStimulus("sub_5_3",      0, 5,     3'b011, 0, 3,     0, 0);
    applyStimulus("sub_n3_n5",    1, 3,     3'b011, 1, 5,     0, 0);
    applyStimulus("mul_n2_5",     1, 2,     3'b100, 0, 5,     0, 0);
    applyStimulus("mul_wrap",     0, 128,   3'b100, 0, 256,   0, 0);
    applyStimulus("add_0_0_hold", 0, 0,     3'b010, 0, 0,     1, 0);
    applyStimulus("sub_add_in_b", 0, 7,     3'b011, 0, 2,     0, 1);

    // Reset in the middle of a multiply must abandon it entirely
    enter_operand(0, 128);
    press_op(3'b100);
    enter_operand(0, 256);
    equal_input = 1'b1;
    @(negedge clk);
    equal_input = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mul_in_progress", 16'(cur_state), 16'(COMPUTE));
    nRST = 1'b1;
    @(negedge clk);
    nRST = 1'b0;
    checkOutput("mid_mul_reset_state", 16'(cur_state), 16'(ENTER_A));
    checkOutput("mid_mul_reset_complete", 16'(complete), 16'd0);
    checkOutput("mid_mul_reset_display", display_output, 16'h0000);
    late = 0;
    repeat (20) begin
      @(negedge clk);
      if (complete) late++;
    end
    checkOutput("no_late_complete", 16'(late), 16'd0);

    keypad_input = 4'd12;
    read_input = 1'b1;
    @(negedge clk);
    read_input = 1'b0;
    checkOutput("digit12_state", 16'(cur_state), 16'(ENTER_A));
    checkOutput("digit12_display", display_output, 16'h0000);
    @(negedge clk);
    applyStimulus("after_digit12", 0, 4, 3'b010, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/gencon.md
Name: gencon

Overview:
- Sequential controller for a 16-bit signed four-function keypad calculator, between the keypad/operator-button decoder and the display driver.
- Accumulates two decimal operands digit by digit, with optional sign toggle on each.
- Latches an operator, computes on "equal", and holds the two's-complement result on the display.
- Exports its FSM state for bench synchronisation.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement).

Ports:
- clk  in  1  system clock, rising-edge.
- nRST  in  1  synchronous, active-high reset, sampled on rising clk.
- keypad_input  in  4  BCD digit, valid when read_input=1.
- read_input  in  1  one-cycle digit strobe.
- operator_input  in  3  001=negate current operand, 010=add, 011=subtract, 100=multiply, 000=none, others ignored.
- equal_input  in  1  level; computes when sampled in ENTER_B.
- complete  out  1  one-cycle pulse when the result is valid.
- display_output  out  16  current operand during entry; result after complete.
- tb_current_state  out  3  state_t encoding of the FSM state (gencon_defs).

Behaviour:
- State encoding: ENTER_A=0, ACC_A=1, OP_LATCH=2, ENTER_B=3, ACC_B=4, COMPUTE=5, DONE=6.
- Reset (nRST=1 at a clk edge):
  - state=ENTER_A; A, B, magnitudes, sign flags and op cleared.
  - complete=0, display_output=0.
  - Reset has priority over everything, including mid-multiply.
- ENTER_A:
  - read_input=1 with keypad 0-9: mag_A <= mag_A*10 + digit (mod 2^16); go to ACC_A. Digits 10-15 are ignored and the state stays put.
  - operator 001: toggle sign_A; stay.
  - operator 010/011/100: latch op, A <= sign_A ? -mag_A : mag_A; go to OP_LATCH.
  - equal_input is ignored.
  - Priority when inputs coincide: operator > digit.
- ACC_A: one cycle, then back to ENTER_A. Strobes arriving here are dropped.
- OP_LATCH: one cycle, clears the B magnitude and sign; go to ENTER_B.
- ENTER_B:
  - Digits and 001 behave as in ENTER_A, but on mag_B/sign_B; a digit goes to ACC_B.
  - operators 010/011/100 are ignored.
  - equal_input=1: B <= sign_B ? -mag_B : mag_B; go to COMPUTE.
  - Priority: equal > operator > digit.
- ACC_B: one cycle, back to ENTER_B.
- COMPUTE:
  - Add and subtract: one cycle, A+B or A-B mod 2^16.
  - Multiply: sequential shift-add of 16 iterations, signed, keeping the low 16 bits of the product.
  - Then go to DONE.
- DONE:
  - complete=1 for exactly this cycle; display_output=result.
  - Next state is ENTER_A, unconditionally, even while equal_input is still high.
  - A new operand is started: magnitudes and signs cleared.
- Display:
  - During entry, display_output shows the signed value of the operand being entered.
  - After DONE, the result is held until the next accepted digit or a reset.
- Overflow: wraps silently, e.g. 128*256 -> 0x8000. Entry magnitude wraps mod 2^16, so negated 32768 = 0x8000 = -32768.
- A zero operand entered as the single digit 0 is valid.
- complete is 0 in every state other than DONE.

Test Plan:
- Reset, enter 2, add, 3, equal -> complete pulse, display_output=0x0005, state returns to 0.
- Negate, 25, add, negate, 15, equal -> 0xFFD8 (-40). Also negate, 10, add, 10 -> 0x0000.
- Negate, 32768, add, 32767, equal -> 0xFFFF. Also 1000 + 2345 -> 0x0D11.
- 5 subtract 3 -> 0x0002. Negate 3 subtract negate 5 -> 0x0002. Negate 2 multiply 5 -> 0xFFF6. 128 multiply 256 -> 0x8000 (wrap).
- Boundaries: 0 add 0 -> 0x0000.
  - equal held high after DONE -> no second computation; state stays 0.
  - Keypad value 12 strobed -> ignored.
  - Add pressed in ENTER_B -> ignored.
  - Reset asserted during a multiply -> state 0, outputs 0.
